// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART sample bridge.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_t;

  localparam int OVF_W = 16;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is still taken when a pop
// happens in the same cycle, so the level stays put.
module sync_fifo
  import uart_bridge_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                        cclk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           head,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; no reset needed since level gates every read.
  always_ff @(posedge cclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge cclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_stream_bridge.sv
// Receiver-to-transmitter sample bridge with decimation, FIFO buffering,
// overflow count, busy LED stretch and VGA offset buttons.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | waiting for data; pops the FIFO head into tx_data
// ST_START     | tx_start is high this cycle
// ST_WAIT_BUSY | waiting for tx_busy; timeout re-issues the same byte
// ST_WAIT_DONE | transfer running; leaves when tx_busy drops
module uart_stream_bridge
  import uart_bridge_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int DECIM_W = 4,
  parameter int SH_W    = 10,
  parameter int LED_W   = 16,
  parameter int BUSY_TO = 3
) (
  input  logic                       cclk,
  input  logic                       reset,
  input  logic                       rx_valid,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic [DECIM_W-1:0]         decim,
  input  logic                       x_inc,
  input  logic                       x_dec,
  input  logic                       y_inc,
  input  logic                       y_dec,
  output logic [SH_W-1:0]            x_sh,
  output logic [SH_W-1:0]            y_sh,
  output logic [level_w(DEPTH)-1:0]  fifo_level,
  output logic [OVF_W-1:0]           overflow_cnt,
  output logic                       busy_led
);

  localparam int TO_W = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

  tx_state_t           state, state_nxt;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_head;
  logic                push_req;
  logic                drop;
  logic [TO_W-1:0]     to_cnt;
  logic [DECIM_W-1:0]  dcnt;
  logic [DECIM_W-1:0]  dlast;
  logic [DECIM_W-1:0]  decim_last;
  logic                armed;
  logic                any_btn;
  logic [LED_W-1:0]    led_cnt;
  logic [LED_W-1:0]    led_cnt_nxt;

  // Last count value of a decimation group; decim of 0 behaves as 1.
  assign decim_last = (decim == '0) ? '0 : decim - DECIM_W'(1);
  assign push_req   = rx_valid && (dcnt == '0);
  assign drop       = push_req && fifo_full && !fifo_pop;
  assign any_btn    = x_inc || x_dec || y_inc || y_dec;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .cclk      (cclk),
    .reset     (reset),
    .push      (push_req),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Decimation counter; the group length is latched at the start of each group.
  always_ff @(posedge cclk) begin
    if (reset) begin
      dcnt  <= '0;
      dlast <= '0;
    end else if (rx_valid) begin
      if (dcnt == '0) begin
        dlast <= decim_last;
        dcnt  <= (decim_last == '0) ? '0 : DECIM_W'(1);
      end else begin
        dcnt  <= (dcnt == dlast) ? '0 : dcnt + DECIM_W'(1);
      end
    end
  end

  // Transmit FSM next-state and pop decode.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy)            state_nxt = ST_WAIT_DONE;
        else if (to_cnt == '0)  state_nxt = ST_START;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_nxt = ST_IDLE;
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Transmit FSM registers; tx_start is registered from the next state.
  always_ff @(posedge cclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      tx_start <= (state_nxt == ST_START);
      if (fifo_pop) tx_data <= fifo_head;
      if (state == ST_START)
        to_cnt <= TO_W'(BUSY_TO - 1);
      else if (state == ST_WAIT_BUSY && to_cnt != '0)
        to_cnt <= to_cnt - TO_W'(1);
    end
  end

  // Dropped-sample counter, saturating.
  always_ff @(posedge cclk) begin
    if (reset) begin
      overflow_cnt <= '0;
    end else if (drop && overflow_cnt != {OVF_W{1'b1}}) begin
      overflow_cnt <= overflow_cnt + OVF_W'(1);
    end
  end

  // One step per press; re-arms after a cycle with all buttons released.
  always_ff @(posedge cclk) begin
    if (reset) begin
      armed <= 1'b1;
      x_sh  <= '0;
      y_sh  <= '0;
    end else if (armed && any_btn) begin
      armed <= 1'b0;
      if (x_inc && !x_dec)      x_sh <= x_sh + SH_W'(1);
      else if (x_dec && !x_inc) x_sh <= x_sh - SH_W'(1);
      if (y_inc && !y_dec)      y_sh <= y_sh + SH_W'(1);
      else if (y_dec && !y_inc) y_sh <= y_sh - SH_W'(1);
    end else if (!any_btn) begin
      armed <= 1'b1;
    end
  end

  // LED stretch down-counter, reloaded while the transmitter is busy.
  always_comb begin
    led_cnt_nxt = led_cnt;
    if (tx_busy)              led_cnt_nxt = '1;
    else if (led_cnt != '0)   led_cnt_nxt = led_cnt - LED_W'(1);
  end

  // Registered LED: matches tx_busy OR (counter != 0) one cycle ahead.
  always_ff @(posedge cclk) begin
    if (reset) begin
      led_cnt  <= '0;
      busy_led <= 1'b0;
    end else begin
      led_cnt  <= led_cnt_nxt;
      busy_led <= tx_busy || (led_cnt_nxt != '0);
    end
  end

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed self-checking bench for uart_stream_bridge.
module tb_uart_stream_bridge;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int DECIM_W = 4;
  localparam int SH_W    = 10;
  localparam int LED_W   = 12;
  localparam int BUSY_TO = 3;

  logic              cclk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [3:0]        decim;
  logic              x_inc, x_dec, y_inc, y_dec;
  logic [9:0]        x_sh, y_sh;
  logic [4:0]        fifo_level;
  logic [15:0]       overflow_cnt;
  logic              busy_led;

  int n_cmp = 0;
  int n_mis = 0;

  uart_stream_bridge #(
    .DATA_W (DATA_W), .DEPTH (DEPTH), .DECIM_W (DECIM_W),
    .SH_W (SH_W), .LED_W (LED_W), .BUSY_TO (BUSY_TO)
  ) dut (
    .cclk (cclk), .reset (reset), .rx_valid (rx_valid), .rx_data (rx_data),
    .tx_busy (tx_busy), .tx_start (tx_start), .tx_data (tx_data),
    .decim (decim), .x_inc (x_inc), .x_dec (x_dec), .y_inc (y_inc),
    .y_dec (y_dec), .x_sh (x_sh), .y_sh (y_sh), .fifo_level (fifo_level),
    .overflow_cnt (overflow_cnt), .busy_led (busy_led)
  );

  always #5 cclk = ~cclk;

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Acts as the transmitter for one byte: find tx_start, check data, run busy.
  task automatic xfer(input logic [7:0] exp, input string tag);
    int n = 0;
    while (tx_start !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    check({tag, "_start"}, tx_start, 1);
    check({tag, "_data"}, tx_data, exp);
    step();
    tx_busy = 1'b1;
    step();
    step();
    tx_busy = 1'b0;
  endtask

  task automatic quiet_window(input string tag);
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx_start === 1'b1) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_busy = 1'b0; decim = 4'd1;
    x_inc = 1'b0; x_dec = 1'b0; y_inc = 1'b0; y_dec = 1'b0;
    step(); step(); step();
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_x_sh", x_sh, 0);
    check("rst_y_sh", y_sh, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow_cnt, 0);
    check("rst_led", busy_led, 0);
    reset = 1'b0;
    step(); step();

    // Single sample: push latency 1, start latency 2, LED stretch.
    rx_valid = 1'b1; rx_data = 8'hA5;
    step();
    rx_valid = 1'b0;
    check("single_level", fifo_level, 1);
    step();
    check("single_start", tx_start, 1);
    check("single_data", tx_data, 8'hA5);
    check("single_level_pop", fifo_level, 0);
    step();
    check("single_pulse_end", tx_start, 0);
    tx_busy = 1'b1;
    for (int i = 0; i < 87; i++) step();
    check("single_led_hold", busy_led, 1);
    check("single_data_hold", tx_data, 8'hA5);
    step();
    tx_busy = 1'b0;
    for (int i = 0; i < (2 ** LED_W) - 2; i++) step();
    check("led_last_high", busy_led, 1);
    step();
    check("led_fall", busy_led, 0);

    // Busy timeout: same byte re-issued every BUSY_TO+1 cycles, no pop.
    rx_valid = 1'b1; rx_data = 8'h3C;
    step();
    rx_data = 8'h3D;
    check("to_level0", fifo_level, 1);
    step();
    rx_valid = 1'b0;
    check("to_start0", tx_start, 1);
    check("to_data0", tx_data, 8'h3C);
    check("to_level1", fifo_level, 1);
    for (int i = 0; i < BUSY_TO; i++) begin
      step();
      check("to_gap", tx_start, 0);
    end
    step();
    check("to_restart", tx_start, 1);
    check("to_redata", tx_data, 8'h3C);
    check("to_level2", fifo_level, 1);
    xfer(8'h3C, "to_x0");
    xfer(8'h3D, "to_x1");
    step(); step(); step();

    // Overflow with busy held: 20 strobes, 17 accepted, 3 dropped.
    tx_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx_valid = 1'b1; rx_data = 8'h40 + 8'(i);
      step();
    end
    rx_valid = 1'b0;
    check("ovf_level", fifo_level, 16);
    check("ovf_cnt", overflow_cnt, 3);
    check("ovf_held", tx_data, 8'h40);

    // Release busy; strobe on the pop cycle while full.
    tx_busy = 1'b0;
    step();
    rx_valid = 1'b1; rx_data = 8'h77;
    step();
    rx_valid = 1'b0;
    check("fullpop_level", fifo_level, 16);
    check("fullpop_ovf", overflow_cnt, 3);
    for (int i = 1; i <= 16; i++) xfer(8'h40 + 8'(i), "ovf_drain");
    xfer(8'h77, "fullpop_x");
    step(); step(); step(); step();
    check("drain_level", fifo_level, 0);

    // Decimation by 4: only 0x80, 0x84, 0x88 go out.
    decim = 4'd4;
    for (int i = 0; i < 12; i++) begin
      rx_valid = 1'b1; rx_data = 8'h80 + 8'(i);
      step();
    end
    rx_valid = 1'b0;
    xfer(8'h80, "dec4_a");
    xfer(8'h84, "dec4_b");
    xfer(8'h88, "dec4_c");
    quiet_window("dec4_no_more");
    check("dec4_level", fifo_level, 0);

    // decim of 0 forwards every sample.
    decim = 4'd0;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1; rx_data = 8'h90 + 8'(i);
      step();
    end
    rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) xfer(8'h90 + 8'(i), "dec0");
    step(); step(); step();

    // Buttons: one step per press, wrap, cancel.
    x_inc = 1'b1;
    step();
    check("xinc_first", x_sh, 1);
    for (int i = 0; i < 49; i++) step();
    x_inc = 1'b0;
    step();
    check("xinc_held", x_sh, 1);
    x_dec = 1'b1;
    step();
    check("xdec_to0", x_sh, 0);
    x_dec = 1'b0;
    step();
    x_dec = 1'b1;
    step();
    x_dec = 1'b0;
    check("xdec_wrap", x_sh, 10'h3FF);
    step();
    y_inc = 1'b1; y_dec = 1'b1;
    step();
    y_inc = 1'b0; y_dec = 1'b0;
    check("y_cancel", y_sh, 0);
    check("y_cancel_x", x_sh, 10'h3FF);
    step();
    y_inc = 1'b1;
    step();
    y_inc = 1'b0;
    check("yinc", y_sh, 1);
    step();

    // Reset mid-transfer abandons the byte and empties the FIFO.
    rx_valid = 1'b1; rx_data = 8'hC1;
    step();
    rx_data = 8'hC2;
    step();
    rx_valid = 1'b0;
    check("mid_start", tx_start, 1);
    reset = 1'b1;
    step();
    check("mid_rst_start", tx_start, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ovf", overflow_cnt, 0);
    check("mid_rst_x", x_sh, 0);
    reset = 1'b0;
    quiet_window("mid_no_retry");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_stream_bridge.md
# uart_stream_bridge

Parametrised sample bridge between the ADC-side `async_receiver` and the PC-side `async_transmitter`, replacing the hand-wired receiver-to-FIFO-to-transmitter path and the button shift logic of the top level. It buffers received samples in a single-clock FIFO and drains them with a start/busy handshake. It also adds optional decimation, overflow accounting, a stretched busy LED and debounced-per-press X/Y offset registers for the VGA controller.

## Interface
- `DATA_W`, 8: sample width, matching the receiver and transmitter data width.
- `DEPTH`, 16: FIFO depth in entries; must be a power of two, at least 2.
- `DECIM_W`, 4: width of the `decim` input.
- `SH_W`, 10: width of the `x_sh` and `y_sh` offset registers.
- `LED_W`, 16: width of the busy-LED stretch counter.
- `BUSY_TO`, 3: maximum cycles allowed from `tx_start` until `tx_busy` rises.

Ports:
- `cclk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in the same cycle.
- `rx_data`  in  DATA_W  received sample.
- `tx_busy`  in  1  transmitter busy flag.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  DATA_W  byte to transmit; held stable from `tx_start` until the transfer completes.
- `decim`  in  DECIM_W  forward one sample in every `decim`; the values 0 and 1 both forward every sample.
- `x_inc`, `x_dec`, `y_inc`, `y_dec`  in  1 each  level-sensitive shift buttons.
- `x_sh`, `y_sh`  out  SH_W each  VGA offset registers.
- `fifo_level`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `overflow_cnt`  out  16  count of dropped samples; saturates.
- `busy_led`  out  1  stretched transmitter-busy indicator.

## Operation
Reset values: `tx_start`=0, `tx_data`=0, `x_sh`=0, `y_sh`=0, `fifo_level`=0, `overflow_cnt`=0, `busy_led`=0. On reset the FIFO is emptied, the FSM enters IDLE, the decimation counter is set to 0 and the button logic is armed. Reset asserted mid-transfer abandons the byte in flight; no retry follows.

Decimation:
- `dcnt` increments on each `rx_valid`.
- A sample is pushed to the FIFO only when `dcnt`==0.
- `dcnt` wraps to 0 after reaching `max(decim,1)-1`.
- A change to `decim` takes effect at the next wrap.

FIFO:
- A push with the FIFO not full is accepted.
- A push with the FIFO full and no pop in the same cycle is dropped, and `overflow_cnt` increments, saturating at 0xFFFF.
- A push with the FIFO full and a pop in the same cycle is accepted; the level is unchanged.
- Read and write pointers wrap modulo DEPTH.

Transmit FSM:
- IDLE: if the FIFO is not empty, pop the head into `tx_data` and go to START.
- START: drive `tx_start`=1 for one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: on `tx_busy`=1 go to WAIT_DONE. If BUSY_TO cycles pass without busy, return to START and re-issue the same byte. No pop occurs on re-issue.
- WAIT_DONE: on `tx_busy`=0 go to IDLE.

Shift buttons:
- While armed and any button is high, every button that is high is applied once: `x_inc` adds 1 to `x_sh`, `x_dec` subtracts 1, and likewise for `y_inc`, `y_dec` on `y_sh`.
- `inc` and `dec` high together on the same axis cancel, leaving that axis unchanged.
- Applying a press disarms the logic; it re-arms once all four buttons have been low for one cycle.
- Offsets wrap modulo 2^SH_W.

Busy LED:
- A `tx_busy`=1 cycle loads the stretch counter with all ones; otherwise the counter decrements toward 0.
- `busy_led` = `tx_busy` OR (counter≠0).

## Timing
- Push latency: a sample strobed in cycle N is in the FIFO and reflected in `fifo_level` at N+1.
- Start latency: with the FIFO empty and the FSM in IDLE, a strobe in cycle N gives the pop at N+1 and `tx_start`=1 in cycle N+2.
- Back-to-back bytes: the next `tx_start` comes no earlier than 2 cycles after `tx_busy` falls.
- Shift update: an offset changes in the cycle after the press is sampled.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `uart_bridge_pkg` holds:
  - the FSM state enum (IDLE, START, WAIT_BUSY, WAIT_DONE);
  - the `OVF_W`=16 constant;
  - a helper for the `fifo_level` width.
- Sub-module `sync_fifo` (parameters DATA_W, DEPTH) provides push/pop, full/empty and level.
- The FSM, decimator, shift logic and LED logic stay in `uart_stream_bridge`.

## Test plan
- Single sample, `decim`=1: `rx_data`=0xA5 strobed in cycle 10 → `tx_start` in cycle 12 with `tx_data`=0xA5. With `tx_busy` high for cycles 13–100, `busy_led` stays high until cycle 100+2^16−1, then falls.
- Overflow, DEPTH=16, `tx_busy` held at 1: 20 strobes → `fifo_level`=16 (one entry is held in `tx_data`, so 17 are accepted), `overflow_cnt`=3. Release busy → the 17 accepted bytes leave in order.
- Full with simultaneous pop: a strobe arrives on the cycle the FSM pops → the sample is accepted, `fifo_level` stays 16 and `overflow_cnt` is unchanged.
- Decimation, `decim`=4: a strobe sequence 0..11 → only 0, 4, 8 are transmitted. With `decim`=0, all samples are transmitted.
- Busy timeout: `tx_busy` never rises → `tx_start` re-pulses every BUSY_TO+1 cycles with the same byte, and `fifo_level` is unchanged.
- Buttons: `x_inc` held for 50 cycles → `x_sh`=1. From `x_sh`=0, a press of `x_dec` → `x_sh`=0x3FF. `y_inc`+`y_dec` pressed together → `y_sh` unchanged. Reset asserted mid-transfer → `tx_start`=0 and `fifo_level`=0 on the next cycle.
